// File: rtl/note_lane_draw_ctrl_if.sv
// Bundle between the note-lane draw sequencer and its neighbours: the frame
// request from the shifter side and the pixel bus to the VGA adapter.
interface note_lane_draw_ctrl_if #(
    parameter int NUM_NOTES = 10
);
    logic                 start;
    logic [NUM_NOTES-1:0] notes;
    logic                 hold;
    logic [7:0]           x;
    logic [6:0]           y;
    logic [2:0]           colour;
    logic                 plot;
    logic                 busy;
    logic                 advance;
    logic                 overrun;

    modport master (
        output start, notes, hold,
        input  x, y, colour, plot, busy, advance, overrun
    );

    modport slave (
        input  start, notes, hold,
        output x, y, colour, plot, busy, advance, overrun
    );
endinterface

// File: rtl/note_lane_draw_ctrl.sv
// Redraws the note lane once per start pulse: snapshots the notes, plots one
// square per note one pixel per clock, then pulses advance for the shifter.
module note_lane_draw_ctrl #(
    parameter int         NUM_NOTES  = 10,
    parameter int         SQ_SIZE    = 4,
    parameter int         X0         = 0,
    parameter int         PITCH      = 5,
    parameter int         Y0         = 60,
    parameter logic [2:0] HIT_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR  = 3'b000
) (
    input  logic               clock,
    input  logic               clear_b,
    note_lane_draw_ctrl_if.slave bus
);
    localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
    localparam int PX_W  = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NOTES - 1);
    localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(SQ_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [NUM_NOTES-1:0] snap, snap_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [PX_W-1:0]      px, px_next;
    logic [PX_W-1:0]      py, py_next;
    logic                 overrun, overrun_next;

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            state   <= IDLE;
            snap    <= '0;
            idx     <= '0;
            px      <= '0;
            py      <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            snap    <= snap_next;
            idx     <= idx_next;
            px      <= px_next;
            py      <= py_next;
            overrun <= overrun_next;
        end
    end

    // Pixel walk runs px fastest, then py, then square index; hold freezes it.
    always_comb begin
        state_next   = state;
        snap_next    = snap;
        idx_next     = idx;
        px_next      = px;
        py_next      = py;
        overrun_next = overrun;
        bus.x        = 8'd0;
        bus.y        = 7'd0;
        bus.colour   = 3'd0;
        bus.plot     = 1'b0;
        bus.busy     = 1'b0;
        bus.advance  = 1'b0;
        bus.overrun  = overrun;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next   = DRAW;
                    snap_next    = bus.notes;
                    idx_next     = '0;
                    px_next      = '0;
                    py_next      = '0;
                    overrun_next = 1'b0;
                end
            end
            DRAW: begin
                bus.busy   = 1'b1;
                bus.plot   = !bus.hold;
                bus.x      = 8'(X0) + 8'(idx) * 8'(PITCH) + 8'(px);
                bus.y      = 7'(Y0) + 7'(py);
                bus.colour = snap[idx] ? HIT_COLOUR : BG_COLOUR;
                if (bus.start) begin
                    overrun_next = 1'b1;
                end
                if (!bus.hold) begin
                    if (px == PX_LAST) begin
                        px_next = '0;
                        if (py == PX_LAST) begin
                            py_next = '0;
                            if (idx == IDX_LAST) begin
                                state_next = DONE;
                            end else begin
                                idx_next = idx + IDX_W'(1);
                            end
                        end else begin
                            py_next = py + PX_W'(1);
                        end
                    end else begin
                        px_next = px + PX_W'(1);
                    end
                end
            end
            DONE: begin
                bus.busy    = 1'b1;
                bus.advance = 1'b1;
                state_next  = IDLE;
                if (bus.start) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_note_lane_draw_ctrl.sv
// Bench for note_lane_draw_ctrl: table of frame scenarios, randomized frames
// against a pixel-list reference model, plus reset sequences.
module tb_note_lane_draw_ctrl;
    localparam int NUM_NOTES = 10;
    localparam int SQ        = 4;
    localparam int X0        = 0;
    localparam int PITCH     = 5;
    localparam int Y0        = 60;
    localparam int NPIX      = NUM_NOTES * SQ * SQ;
    localparam int BUDGET    = 1000;

    typedef struct {
        logic [NUM_NOTES-1:0] notes;
        int                   hold_at;
        int                   hold_len;
        int                   start_at;
        bit                   change_notes;
        int                   exp_adv_cyc;
        int                   exp_overrun;
    } vec_t;

    logic clock;
    logic clear_b;
    int   total;
    int   bad;
    int   seen_x [NPIX];
    int   seen_y [NPIX];
    int   seen_c [NPIX];
    vec_t vecs [6];

    note_lane_draw_ctrl_if #(.NUM_NOTES(NUM_NOTES)) bus ();

    note_lane_draw_ctrl dut (
        .clock   (clock),
        .clear_b (clear_b),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pixel n of a frame from the drawing rules: square n/16, row and column within it.
    function automatic void ref_pixel(input int n, input logic [NUM_NOTES-1:0] snap,
                                      output int ex, output int ey, output int ec);
        int sq;
        int r;
        sq = n / (SQ * SQ);
        r  = n % (SQ * SQ);
        ex = X0 + sq * PITCH + (r % SQ);
        ey = Y0 + (r / SQ);
        ec = snap[sq] ? 4 : 0;
    endfunction

    task automatic apply_stimulus(input logic s, input logic [NUM_NOTES-1:0] n, input logic h);
        bus.start = s;
        bus.notes = n;
        bus.hold  = h;
    endtask

    // Runs one frame from IDLE; entered and left at 1 time unit after a rising edge.
    task automatic run_frame(input vec_t v, input bit rnd);
        int  pix_n;
        int  held;
        int  adv_cyc;
        int  ex, ey, ec;
        bit  after_last;
        bit  done;
        bit  ov_model;
        logic hold_now;
        logic start_now;
        logic [NUM_NOTES-1:0] nts;

        pix_n = 0; held = 0; adv_cyc = -1;
        after_last = 0; done = 0; ov_model = 0;

        apply_stimulus(1'b1, v.notes, 1'b0);
        #4;
        check_output("idle_busy_before_start", int'(bus.busy), 0);
        @(posedge clock); #1;

        for (int cyc = 1; cyc <= BUDGET && !done; cyc++) begin
            if (rnd) begin
                hold_now  = ($urandom_range(0, 3) == 0);
                start_now = ($urandom_range(0, 29) == 0);
                nts       = NUM_NOTES'($urandom);
            end else begin
                hold_now  = (pix_n == v.hold_at && held < v.hold_len);
                start_now = (cyc == v.start_at);
                nts       = v.change_notes ? '0 : v.notes;
            end
            if (hold_now && !after_last) held++;
            apply_stimulus(start_now, nts, hold_now);
            #4;
            if (cyc == 1) check_output("overrun_cleared_on_accept", int'(bus.overrun), 0);
            check_output("busy_in_frame", int'(bus.busy), 1);
            if (after_last) begin
                check_output("advance_pulse", int'(bus.advance), 1);
                check_output("plot_in_done", int'(bus.plot), 0);
                adv_cyc = cyc;
                done    = 1;
            end else begin
                check_output("advance_early", int'(bus.advance), 0);
                ref_pixel(pix_n, v.notes, ex, ey, ec);
                if (hold_now) begin
                    check_output("plot_under_hold", int'(bus.plot), 0);
                    check_output("x_frozen", int'(bus.x), ex);
                    check_output("y_frozen", int'(bus.y), ey);
                end else begin
                    check_output("plot_active", int'(bus.plot), 1);
                    check_output("pixel_x", int'(bus.x), ex);
                    check_output("pixel_y", int'(bus.y), ey);
                    check_output("pixel_colour", int'(bus.colour), ec);
                    seen_x[pix_n] = int'(bus.x);
                    seen_y[pix_n] = int'(bus.y);
                    seen_c[pix_n] = int'(bus.colour);
                    pix_n++;
                    if (pix_n == NPIX) after_last = 1;
                end
            end
            if (start_now) ov_model = 1;
            @(posedge clock); #1;
        end

        check_output("frame_completed_in_budget", int'(done), 1);
        check_output("plot_count", pix_n, NPIX);
        apply_stimulus(1'b0, v.notes, 1'b0);
        #4;
        check_output("idle_busy_after", int'(bus.busy), 0);
        check_output("idle_plot_after", int'(bus.plot), 0);
        check_output("idle_advance_after", int'(bus.advance), 0);
        if (rnd) begin
            check_output("overrun_random", int'(bus.overrun), int'(ov_model));
        end else begin
            check_output("overrun_table", int'(bus.overrun), v.exp_overrun);
            check_output("advance_cycle", adv_cyc, v.exp_adv_cyc);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        vec_t rv;
        int   plots;
        total = 0;
        bad   = 0;

        vecs[0] = '{10'h001, -1,  0,  -1, 1'b0, 161, 0};
        vecs[1] = '{10'h200, -1,  0,  -1, 1'b1, 161, 0};
        vecs[2] = '{10'h2AA, 37,  3,  -1, 1'b0, 164, 0};
        vecs[3] = '{10'h155, -1,  0,  50, 1'b0, 161, 1};
        vecs[4] = '{10'h3FF,  0,  2, 163, 1'b0, 163, 1};
        vecs[5] = '{10'h000, 159, 1,  -1, 1'b0, 162, 0};

        clear_b = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0);
        #12;
        check_output("reset_x", int'(bus.x), 0);
        check_output("reset_y", int'(bus.y), 0);
        check_output("reset_colour", int'(bus.colour), 0);
        check_output("reset_plot", int'(bus.plot), 0);
        check_output("reset_busy", int'(bus.busy), 0);
        check_output("reset_advance", int'(bus.advance), 0);
        check_output("reset_overrun", int'(bus.overrun), 0);
        @(posedge clock); #1;
        clear_b = 1'b1;

        for (int c = 0; c < 20; c++) begin
            #4;
            check_output("idle_plot", int'(bus.plot), 0);
            check_output("idle_advance", int'(bus.advance), 0);
            check_output("idle_busy", int'(bus.busy), 0);
            @(posedge clock); #1;
        end

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], 1'b0);
            if (i == 0) begin
                check_output("first_x", seen_x[0], 0);
                check_output("first_y", seen_y[0], 60);
                check_output("first_colour", seen_c[0], 4);
                check_output("pix16_x", seen_x[16], 5);
                check_output("pix16_colour", seen_c[16], 0);
                check_output("last_x", seen_x[NPIX-1], 48);
                check_output("last_y", seen_y[NPIX-1], 63);
                check_output("last_colour", seen_c[NPIX-1], 0);
            end
        end

        for (int i = 0; i < 8; i++) begin
            rv = '{NUM_NOTES'($urandom), -1, 0, -1, 1'b1, -1, 0};
            run_frame(rv, 1'b1);
        end

        // Reset asserted asynchronously after 80 plotted pixels.
        apply_stimulus(1'b1, 10'h3FF, 1'b0);
        @(posedge clock); #1;
        apply_stimulus(1'b0, 10'h3FF, 1'b0);
        plots = 0;
        for (int c = 0; c < BUDGET && plots < 80; c++) begin
            #4;
            if (bus.plot) plots++;
            @(posedge clock); #1;
        end
        check_output("reached_pixel_80", plots, 80);
        clear_b = 1'b0;
        #1;
        check_output("midreset_plot", int'(bus.plot), 0);
        check_output("midreset_busy", int'(bus.busy), 0);
        check_output("midreset_advance", int'(bus.advance), 0);
        @(posedge clock); #1;
        clear_b = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #4;
            check_output("post_reset_advance", int'(bus.advance), 0);
            check_output("post_reset_plot", int'(bus.plot), 0);
            @(posedge clock); #1;
        end
        run_frame(vecs[0], 1'b0);
        check_output("after_reset_first_x", seen_x[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
